riscv_regfile_wb_arbiter: RTL and testbench

//  Shares the register file's single write port between two writeback sources:
//  src0 = ALU/execute, src1 = load unit. Arbitrates with a valid/ready handshake and

---
 rtl/riscv_regfile_wb_arbiter.sv | 179 +++++++++++++++++
 tb/tb_riscv_regfile_wb_arbiter.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/riscv_regfile_wb_arbiter.sv
// ----------------------------------------------------------------------------
// riscv_regfile_wb_arbiter
//
// Shares the register file's single write port between two writeback sources:
// src0 (ALU / execute) and src1 (load unit). A valid/ready handshake selects at
// most one source per cycle. The selected write is registered onto the regfile
// write port, so the regfile captures it one edge after it is accepted.
//
// A 32-entry pending-write scoreboard tracks destination registers reserved by
// decode at issue. A busy bit clears only at the edge where the regfile
// captures the matching write, so decode can never read stale data after busy
// drops.
//
// Parameters
//   XLEN      data width
//   ARB_MODE  0 = round-robin, 1 = fixed priority (src1 / load always wins)
//
// Ports
//   i_clk, i_rst                  clock, synchronous active-high reset
//   i_wb0_valid/addr/data         src0 write request
//   o_wb0_ready                   src0 granted this cycle (combinational)
//   i_wb1_valid/addr/data         src1 write request
//   o_wb1_ready                   src1 granted this cycle (combinational)
//   i_sb_set_valid/addr           decode reserves a destination register
//   o_sb_busy                     per-register pending-write flags (bit 0 = 0)
//   o_sb_err                      sticky: reservation of an already-busy register
//   o_regfile_rd_wen/addr/data    registered write port to the register file
// ----------------------------------------------------------------------------
module riscv_regfile_wb_arbiter #(
   parameter int unsigned XLEN     = 32,
   parameter int unsigned ARB_MODE = 0
) (
   input  logic            i_clk,
   input  logic            i_rst,

   input  logic            i_wb0_valid,
   output logic            o_wb0_ready,
   input  logic [4:0]      i_wb0_addr,
   input  logic [XLEN-1:0] i_wb0_data,

   input  logic            i_wb1_valid,
   output logic            o_wb1_ready,
   input  logic [4:0]      i_wb1_addr,
   input  logic [XLEN-1:0] i_wb1_data,

   input  logic            i_sb_set_valid,
   input  logic [4:0]      i_sb_set_addr,
   output logic [31:0]     o_sb_busy,
   output logic            o_sb_err,

   output logic            o_regfile_rd_wen,
   output logic [4:0]      o_regfile_rd_addr,
   output logic [XLEN-1:0] o_regfile_rd_data
);

   // -------------------------------------------------------------------------
   // State
   // -------------------------------------------------------------------------
   // prio_q names the source that wins the next contended cycle in round-robin
   // mode (0 = src0, 1 = src1). It moves only when a grant is issued.
   logic            prio_q, prio_d;

   logic            wen_q, wen_d;
   logic [4:0]      addr_q, addr_d;
   logic [XLEN-1:0] data_q, data_d;

   logic [31:0]     busy_q, busy_d;
   logic            err_q, err_d;

   // -------------------------------------------------------------------------
   // Arbitration
   // -------------------------------------------------------------------------
   logic gnt0, gnt1;

   // Grants look only at the valids and the priority pointer, never at the
   // request payload. Both readies are held low during reset.
   always_comb begin
      gnt0 = 1'b0;
      gnt1 = 1'b0;
      if (!i_rst) begin
         if (i_wb0_valid && i_wb1_valid) begin
            if (ARB_MODE == 1) begin
               gnt1 = 1'b1;
            end else if (prio_q) begin
               gnt1 = 1'b1;
            end else begin
               gnt0 = 1'b1;
            end
         end else begin
            gnt0 = i_wb0_valid;
            gnt1 = i_wb1_valid;
         end
      end
   end

   assign o_wb0_ready = gnt0;
   assign o_wb1_ready = gnt1;

   // -------------------------------------------------------------------------
   // Write-port next state
   // -------------------------------------------------------------------------
   logic            xfer;
   logic [4:0]      sel_addr;
   logic [XLEN-1:0] sel_data;
   logic            commit;

   always_comb begin
      xfer     = gnt0 | gnt1;
      sel_addr = gnt1 ? i_wb1_addr : i_wb0_addr;
      sel_data = gnt1 ? i_wb1_data : i_wb0_data;
      // Writes to x0 complete the handshake but never reach the regfile.
      commit   = xfer && (sel_addr != 5'd0);

      wen_d    = commit;
      addr_d   = commit ? sel_addr : addr_q;
      data_d   = commit ? sel_data : data_q;

      prio_d   = prio_q;
      if (gnt0) begin
         prio_d = 1'b1;
      end else if (gnt1) begin
         prio_d = 1'b0;
      end
   end

   // -------------------------------------------------------------------------
   // Scoreboard next state
   // -------------------------------------------------------------------------
   logic [31:0] clr_vec;
   logic [31:0] set_vec;

   always_comb begin
      clr_vec = 32'd0;
      set_vec = 32'd0;
      // Clear on the edge where the regfile captures the registered write.
      if (wen_q) begin
         clr_vec = 32'd1 << addr_q;
      end
      if (i_sb_set_valid && (i_sb_set_addr != 5'd0)) begin
         set_vec = 32'd1 << i_sb_set_addr;
      end

      // Set is applied after clear, so a same-cycle set/clear leaves the bit 1.
      busy_d    = (busy_q & ~clr_vec) | set_vec;
      busy_d[0] = 1'b0;

      // A reservation that collides with a write committing this same edge is
      // a normal re-issue, not an error.
      err_d = err_q | (|(set_vec & busy_q & ~clr_vec));
   end

   // -------------------------------------------------------------------------
   // Registers
   // -------------------------------------------------------------------------
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         prio_q <= 1'b0;
         wen_q  <= 1'b0;
         addr_q <= 5'd0;
         data_q <= '0;
         busy_q <= 32'd0;
         err_q  <= 1'b0;
      end else begin
         prio_q <= prio_d;
         wen_q  <= wen_d;
         addr_q <= addr_d;
         data_q <= data_d;
         busy_q <= busy_d;
         err_q  <= err_d;
      end
   end

   assign o_regfile_rd_wen  = wen_q;
   assign o_regfile_rd_addr = addr_q;
   assign o_regfile_rd_data = data_q;
   assign o_sb_busy         = busy_q;
   assign o_sb_err          = err_q;

endmodule

// File: tb/tb_riscv_regfile_wb_arbiter.sv
// ----------------------------------------------------------------------------
// tb_riscv_regfile_wb_arbiter
//
// Directed bench. Two instances share one set of stimulus: u_rr uses
// round-robin arbitration, u_fp uses fixed priority. Inputs change 1 time unit
// after the rising edge; outputs are sampled at that point or later.
// ----------------------------------------------------------------------------
module tb_riscv_regfile_wb_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        wb0_valid, wb1_valid;
   logic [4:0]  wb0_addr, wb1_addr;
   logic [31:0] wb0_data, wb1_data;
   logic        sb_set_valid;
   logic [4:0]  sb_set_addr;

   logic        rr_ready0, rr_ready1, rr_wen, rr_err;
   logic [4:0]  rr_addr;
   logic [31:0] rr_data, rr_busy;
   logic        fp_ready0, fp_ready1, fp_wen, fp_err;
   logic [4:0]  fp_addr;
   logic [31:0] fp_data, fp_busy;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   riscv_regfile_wb_arbiter #(.XLEN(32), .ARB_MODE(0)) u_rr (
      .i_clk(clk), .i_rst(rst),
      .i_wb0_valid(wb0_valid), .o_wb0_ready(rr_ready0),
      .i_wb0_addr(wb0_addr), .i_wb0_data(wb0_data),
      .i_wb1_valid(wb1_valid), .o_wb1_ready(rr_ready1),
      .i_wb1_addr(wb1_addr), .i_wb1_data(wb1_data),
      .i_sb_set_valid(sb_set_valid), .i_sb_set_addr(sb_set_addr),
      .o_sb_busy(rr_busy), .o_sb_err(rr_err),
      .o_regfile_rd_wen(rr_wen), .o_regfile_rd_addr(rr_addr),
      .o_regfile_rd_data(rr_data)
   );

   riscv_regfile_wb_arbiter #(.XLEN(32), .ARB_MODE(1)) u_fp (
      .i_clk(clk), .i_rst(rst),
      .i_wb0_valid(wb0_valid), .o_wb0_ready(fp_ready0),
      .i_wb0_addr(wb0_addr), .i_wb0_data(wb0_data),
      .i_wb1_valid(wb1_valid), .o_wb1_ready(fp_ready1),
      .i_wb1_addr(wb1_addr), .i_wb1_data(wb1_data),
      .i_sb_set_valid(sb_set_valid), .i_sb_set_addr(sb_set_addr),
      .o_sb_busy(fp_busy), .o_sb_err(fp_err),
      .o_regfile_rd_wen(fp_wen), .o_regfile_rd_addr(fp_addr),
      .o_regfile_rd_data(fp_data)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst          = 1'b1;
      wb0_valid    = 1'b0; wb0_addr = 5'd0; wb0_data = 32'd0;
      wb1_valid    = 1'b0; wb1_addr = 5'd0; wb1_data = 32'd0;
      sb_set_valid = 1'b0; sb_set_addr = 5'd0;

      // ---- Reset state ----
      step();
      step();
      wb0_valid = 1'b1; wb1_valid = 1'b1;
      #1;
      check("rst_wen",    {31'd0, rr_wen},    32'd0);
      check("rst_busy",   rr_busy,            32'd0);
      check("rst_err",    {31'd0, rr_err},    32'd0);
      check("rst_ready0", {31'd0, rr_ready0}, 32'd0);
      check("rst_ready1", {31'd0, fp_ready1}, 32'd0);
      wb0_valid = 1'b0; wb1_valid = 1'b0;
      rst = 1'b0;

      // ---- Contention: round-robin alternates, fixed always picks src1 ----
      wb0_valid = 1'b1; wb0_addr = 5'd1; wb0_data = 32'h0000_0011;
      wb1_valid = 1'b1; wb1_addr = 5'd2; wb1_data = 32'h0000_0022;
      for (int k = 0; k < 4; k++) begin
         #1;
         check($sformatf("rr_ready0_%0d", k), {31'd0, rr_ready0}, (k % 2 == 0) ? 32'd1 : 32'd0);
         check($sformatf("rr_ready1_%0d", k), {31'd0, rr_ready1}, (k % 2 == 1) ? 32'd1 : 32'd0);
         check($sformatf("fp_ready0_%0d", k), {31'd0, fp_ready0}, 32'd0);
         check($sformatf("fp_ready1_%0d", k), {31'd0, fp_ready1}, 32'd1);
         step();
         check($sformatf("rr_wen_%0d", k),  {31'd0, rr_wen}, 32'd1);
         check($sformatf("rr_addr_%0d", k), {27'd0, rr_addr}, (k % 2 == 0) ? 32'd1 : 32'd2);
         check($sformatf("rr_data_%0d", k), rr_data,
               (k % 2 == 0) ? 32'h0000_0011 : 32'h0000_0022);
         check($sformatf("fp_addr_%0d", k), {27'd0, fp_addr}, 32'd2);
      end
      wb0_valid = 1'b0; wb1_valid = 1'b0;
      step();
      check("idle_wen",  {31'd0, rr_wen},  32'd0);
      check("idle_addr", {27'd0, rr_addr}, 32'd2);

      // ---- Lone src0 request, one-cycle latency ----
      wb0_valid = 1'b1; wb0_addr = 5'd5; wb0_data = 32'hDEAD_BEEF;
      #1;
      check("t1_ready0", {31'd0, rr_ready0}, 32'd1);
      check("t1_ready1", {31'd0, rr_ready1}, 32'd0);
      step();
      wb0_valid = 1'b0;
      check("t1_wen",  {31'd0, rr_wen},  32'd1);
      check("t1_addr", {27'd0, rr_addr}, 32'd5);
      check("t1_data", rr_data,          32'hDEAD_BEEF);
      check("t1_busy", rr_busy,          32'd0);
      step();
      check("t1_wen_off", {31'd0, rr_wen}, 32'd0);

      // ---- Scoreboard set, then src1 commit clears it ----
      sb_set_valid = 1'b1; sb_set_addr = 5'd7;
      step();
      sb_set_valid = 1'b0;
      check("t3_busy_set", rr_busy, 32'h0000_0080);
      wb1_valid = 1'b1; wb1_addr = 5'd7; wb1_data = 32'h0000_0077;
      #1;
      check("t3_ready1", {31'd0, rr_ready1}, 32'd1);
      step();
      wb1_valid = 1'b0;
      check("t3_wen",       {31'd0, rr_wen}, 32'd1);
      check("t3_busy_hold", rr_busy,         32'h0000_0080);
      step();
      check("t3_busy_clr", rr_busy,         32'd0);
      check("t3_err",      {31'd0, rr_err}, 32'd0);

      // ---- Set collides with commit: set wins, no error; then sticky error ----
      sb_set_valid = 1'b1; sb_set_addr = 5'd7;
      step();
      sb_set_valid = 1'b0;
      wb0_valid = 1'b1; wb0_addr = 5'd7; wb0_data = 32'h0000_0070;
      step();
      wb0_valid = 1'b0;
      check("t4_wen", {31'd0, rr_wen}, 32'd1);
      sb_set_valid = 1'b1; sb_set_addr = 5'd7;
      step();
      sb_set_valid = 1'b0;
      check("t4_busy_kept", rr_busy,         32'h0000_0080);
      check("t4_no_err",    {31'd0, rr_err}, 32'd0);
      sb_set_valid = 1'b1; sb_set_addr = 5'd7;
      step();
      sb_set_valid = 1'b0;
      check("t4_err",      {31'd0, rr_err}, 32'd1);
      check("t4_busy_err", rr_busy,         32'h0000_0080);
      step();
      step();
      check("t4_err_sticky", {31'd0, rr_err}, 32'd1);

      // ---- Write to x0 ----
      wb0_valid = 1'b1; wb0_addr = 5'd0; wb0_data = 32'hFFFF_FFFF;
      #1;
      check("t5_ready0", {31'd0, rr_ready0}, 32'd1);
      step();
      wb0_valid = 1'b0;
      check("t5_wen",  {31'd0, rr_wen}, 32'd0);
      check("t5_busy", rr_busy,         32'h0000_0080);

      // ---- Reset with a write to x9 pending ----
      sb_set_valid = 1'b1; sb_set_addr = 5'd9;
      step();
      sb_set_valid = 1'b0;
      check("t6_busy9", rr_busy, 32'h0000_0280);
      wb0_valid = 1'b1; wb0_addr = 5'd9; wb0_data = 32'h0000_0099;
      step();
      check("t6_wen_pend", {31'd0, rr_wen}, 32'd1);
      rst = 1'b1;
      wb0_valid = 1'b1; wb0_addr = 5'd3; wb0_data = 32'h0000_0033;
      wb1_valid = 1'b1; wb1_addr = 5'd4; wb1_data = 32'h0000_0044;
      #1;
      check("t6_rst_ready0", {31'd0, rr_ready0}, 32'd0);
      check("t6_rst_ready1", {31'd0, rr_ready1}, 32'd0);
      step();
      check("t6_wen",  {31'd0, rr_wen}, 32'd0);
      check("t6_busy", rr_busy,         32'd0);
      check("t6_err",  {31'd0, rr_err}, 32'd0);
      rst = 1'b0;
      #1;
      check("t6_first_ready0", {31'd0, rr_ready0}, 32'd1);
      check("t6_first_ready1", {31'd0, rr_ready1}, 32'd0);
      step();
      wb0_valid = 1'b0; wb1_valid = 1'b0;
      check("t6_first_addr", {27'd0, rr_addr}, 32'd3);
      check("t6_fp_addr",    {27'd0, fp_addr}, 32'd4);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
